// File: rtl/fp32_pkg.sv
// Shared IEEE-754 single-precision constants, field widths and operand
// classification used by the fp32 arithmetic blocks.
package fp32_pkg;

  localparam int EXP_W     = 8;
  localparam int MAN_W     = 23;
  localparam int FP32_BIAS = 127;

  localparam logic [31:0] FP32_QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] FP32_POS_INF = 32'h7F80_0000;
  localparam logic [31:0] FP32_HALF    = 32'h3F00_0000;
  localparam logic [31:0] FP32_ONE     = 32'h3F80_0000;

  typedef enum logic [2:0] {
    CLS_ZERO   = 3'd0,
    CLS_DENORM = 3'd1,
    CLS_NORMAL = 3'd2,
    CLS_INF    = 3'd3,
    CLS_NAN    = 3'd4
  } fp_class_e;

endpackage

// File: rtl/fp32_unpack.sv
// Splits a single-precision operand into sign / exponent / mantissa with the
// hidden bit restored and reports its class. Denormals are flushed: they are
// flagged as zero and their mantissa is forced to 0.
//   data    : raw IEEE-754 single
//   sign    : sign bit
//   expo    : biased exponent field
//   man     : 24-bit significand, hidden 1 included (0 unless normal)
//   is_zero : zero or denormal
//   is_inf  : +/- infinity
//   is_nan  : any NaN
module fp32_unpack
  import fp32_pkg::*;
(
  input  logic [31:0]      data,
  output logic             sign,
  output logic [EXP_W-1:0] expo,
  output logic [MAN_W:0]   man,
  output logic             is_zero,
  output logic             is_inf,
  output logic             is_nan
);

  logic [MAN_W-1:0] frac;
  fp_class_e        cls;

  assign sign = data[31];
  assign expo = data[30:23];
  assign frac = data[22:0];

  always_comb begin
    cls = CLS_NORMAL;
    if (expo == '0)      cls = (frac == '0) ? CLS_ZERO : CLS_DENORM;
    else if (expo == '1) cls = (frac == '0) ? CLS_INF  : CLS_NAN;
  end

  assign man     = (cls == CLS_NORMAL) ? {1'b1, frac} : '0;
  assign is_zero = (cls == CLS_ZERO) || (cls == CLS_DENORM);
  assign is_inf  = (cls == CLS_INF);
  assign is_nan  = (cls == CLS_NAN);

endmodule

// File: rtl/fp_mul32.sv
// Three-stage pipelined single-precision multiplier, result = dataa * datab.
// Round to nearest even, denormals flushed to zero, canonical qNaN output.
//   clk    : rising-edge clock
//   rst    : synchronous active-high reset, clears every stage (beats clk_en)
//   clk_en : pipeline advance; all stages hold when low
//   dataa  : operand A
//   datab  : operand B
//   result : product, valid on the 3rd enabled edge after operands sampled
module fp_mul32
  import fp32_pkg::*;
#(
  parameter int FLT_WIDTH = 32,
  parameter int LATENCY   = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clk_en,
  input  logic [FLT_WIDTH-1:0] dataa,
  input  logic [FLT_WIDTH-1:0] datab,
  output logic [FLT_WIDTH-1:0] result
);

  if (FLT_WIDTH != 32 || LATENCY != 3) begin : g_bad_param
    $error("fp_mul32 supports only FLT_WIDTH=32, LATENCY=3");
  end

  // ---------------- stage 1: unpack, classify, multiply ----------------
  logic             sa, sb;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W:0]   ma, mb;
  logic             za, zb, ia, ib, na, nb;

  fp32_unpack u_unpack_a (.data(dataa), .sign(sa), .expo(ea), .man(ma),
                          .is_zero(za), .is_inf(ia), .is_nan(na));
  fp32_unpack u_unpack_b (.data(datab), .sign(sb), .expo(eb), .man(mb),
                          .is_zero(zb), .is_inf(ib), .is_nan(nb));

  logic               s1_sign, s1_nan, s1_inf, s1_zero;
  logic signed [9:0]  s1_exp;
  logic [47:0]        s1_prod;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_sign <= 1'b0; s1_nan <= 1'b0; s1_inf <= 1'b0; s1_zero <= 1'b0;
      s1_exp  <= '0;   s1_prod <= '0;
    end else if (clk_en) begin
      s1_sign <= sa ^ sb;
      // inf * zero is invalid and folds into the NaN case
      s1_nan  <= na | nb | (ia & zb) | (ib & za);
      s1_inf  <= ia | ib;
      s1_zero <= za | zb;
      s1_exp  <= $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'(FP32_BIAS);
      s1_prod <= ma * mb;
    end
  end

  // ---------------- stage 2: normalize, guard/sticky ----------------
  logic               s2_sign, s2_nan, s2_inf, s2_zero;
  logic signed [9:0]  s2_exp;
  logic [23:0]        s2_man;
  logic               s2_guard, s2_sticky;

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_sign <= 1'b0; s2_nan <= 1'b0; s2_inf <= 1'b0; s2_zero <= 1'b0;
      s2_exp  <= '0;   s2_man <= '0;   s2_guard <= 1'b0; s2_sticky <= 1'b0;
    end else if (clk_en) begin
      s2_sign <= s1_sign;
      s2_nan  <= s1_nan;
      s2_inf  <= s1_inf;
      s2_zero <= s1_zero;
      // product of two [1,2) significands lies in [1,4): at most one shift
      if (s1_prod[47]) begin
        s2_exp    <= s1_exp + 10'sd1;
        s2_man    <= s1_prod[47:24];
        s2_guard  <= s1_prod[23];
        s2_sticky <= |s1_prod[22:0];
      end else begin
        s2_exp    <= s1_exp;
        s2_man    <= s1_prod[46:23];
        s2_guard  <= s1_prod[22];
        s2_sticky <= |s1_prod[21:0];
      end
    end
  end

  // ---------------- stage 3: round, exceptions, pack ----------------
  logic              round_up;
  logic [24:0]       man_rnd;
  logic [23:0]       man_fin;
  logic signed [9:0] exp_fin;
  logic [31:0]       packed_res;

  always_comb begin
    round_up = s2_guard & (s2_sticky | s2_man[0]);
    man_rnd  = {1'b0, s2_man} + 25'(round_up);
    man_fin  = man_rnd[23:0];
    exp_fin  = s2_exp;
    // carry out means the significand rounded up to 2.0
    if (man_rnd[24]) begin
      man_fin = 24'h80_0000;
      exp_fin = s2_exp + 10'sd1;
    end

    packed_res = {s2_sign, exp_fin[7:0], man_fin[22:0]};
    if (s2_nan)                    packed_res = FP32_QNAN;
    else if (s2_inf)               packed_res = {s2_sign, FP32_POS_INF[30:0]};
    else if (s2_zero)              packed_res = {s2_sign, 31'd0};
    else if (exp_fin >= 10'sd255)  packed_res = {s2_sign, FP32_POS_INF[30:0]};
    else if (exp_fin <= 10'sd0)    packed_res = {s2_sign, 31'd0};
  end

  always_ff @(posedge clk) begin
    if (rst)         result <= '0;
    else if (clk_en) result <= packed_res;
  end

endmodule

// File: tb/tb_fp_mul32.sv
// Directed-vector bench for fp_mul32: latency, streaming, rounding,
// exception handling, clk_en stall and reset behaviour.
module tb_fp_mul32;

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_en;
  logic [31:0] dataa, datab;
  logic [31:0] result;

  int checks   = 0;
  int failures = 0;

  fp_mul32 dut (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .dataa(dataa), .datab(datab), .result(result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam int NV = 12;
  logic [31:0] va [NV] = '{32'h4040_0000, 32'h3FC0_0000, 32'h3F80_0001, 32'hC000_0000,
                           32'h7F00_0000, 32'h7F80_0000, 32'h7FC0_0000, 32'h0080_0000,
                           32'h0040_0000, 32'h8000_0000, 32'h3F80_0000, 32'h4000_0000};
  logic [31:0] vb [NV] = '{32'h3F00_0000, 32'h3FC0_0000, 32'h3F80_0001, 32'h3F00_0000,
                           32'h7F00_0000, 32'h0000_0000, 32'h3F80_0000, 32'h0080_0000,
                           32'h4000_0000, 32'h3F80_0000, 32'hFF80_0000, 32'h4040_0000};
  logic [31:0] ve [NV] = '{32'h3FC0_0000, 32'h4010_0000, 32'h3F80_0002, 32'hBF80_0000,
                           32'h7F80_0000, 32'h7FC0_0000, 32'h7FC0_0000, 32'h0000_0000,
                           32'h0000_0000, 32'h8000_0000, 32'hFF80_0000, 32'h40C0_0000};

  initial begin
    rst = 1'b1; clk_en = 1'b0; dataa = '0; datab = '0;
    tick(); tick();
    chk("reset_state", result, 32'h0);
    rst = 1'b0; clk_en = 1'b1;

    // single product: exactly three enabled edges
    dataa = 32'h4040_0000; datab = 32'h3F00_0000;
    tick(); dataa = '0; datab = '0;
    chk("lat_edge1", result, 32'h0);
    tick();
    chk("lat_edge2", result, 32'h0);
    tick();
    chk("lat_edge3", result, 32'h3FC0_0000);

    // back-to-back stream: vector j lands on the 3rd edge after it is driven
    for (int i = 0; i < NV + 2; i++) begin
      if (i < NV) begin dataa = va[i]; datab = vb[i]; end
      else begin dataa = '0; datab = '0; end
      tick();
      if (i >= 2) chk($sformatf("vec%0d", i - 2), result, ve[i - 2]);
    end

    // clk_en stall
    rst = 1'b1; tick(); rst = 1'b0;
    dataa = 32'h3FC0_0000; datab = 32'h3FC0_0000; clk_en = 1'b1;
    tick();
    clk_en = 1'b0; dataa = 32'h7FC0_0000; datab = 32'h7FC0_0000;
    for (int i = 0; i < 5; i++) tick();
    chk("stall_hold", result, 32'h0);
    clk_en = 1'b1; dataa = '0; datab = '0;
    tick();
    chk("stall_en1", result, 32'h0);
    tick();
    chk("stall_en2", result, 32'h4010_0000);
    clk_en = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("stall_result_hold", result, 32'h4010_0000);

    // reset mid-stream discards in-flight products
    clk_en = 1'b1;
    dataa = 32'h4040_0000; datab = 32'h3F00_0000; tick();
    dataa = 32'h3FC0_0000; datab = 32'h3FC0_0000; tick();
    dataa = 32'hC000_0000; datab = 32'h3F00_0000; tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_mid", result, 32'h0);
    dataa = 32'h4040_0000; datab = 32'h3F00_0000; tick();
    dataa = '0; datab = '0;
    chk("rst_flush1", result, 32'h0);
    tick();
    chk("rst_flush2", result, 32'h0);
    tick();
    chk("rst_new", result, 32'h3FC0_0000);

    // reset beats clk_en=0
    clk_en = 1'b0; rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_no_en", result, 32'h0);
    clk_en = 1'b1; tick(); tick();
    chk("rst_no_en_stages", result, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
